// File: rtl/jt12_pcm_feeder_if.sv
// Bus between the CPU/register side and the PCM feeder: sample pushes, pacing control and strobe outputs.
interface jt12_pcm_feeder_if #(
  parameter int DW   = 9,
  parameter int AW   = 4,
  parameter int PERW = 8
);
  logic            cen55;
  logic            clr;
  logic            enable;
  logic [PERW-1:0] period;
  logic            din_we;
  logic [DW-1:0]   din;
  logic            full;
  logic            empty;
  logic [AW:0]     level;
  logic            overflow;
  logic            underrun;
  logic            pcm_wr;
  logic [DW-1:0]   pcmout;

  modport master (
    output cen55, clr, enable, period, din_we, din,
    input  full, empty, level, overflow, underrun, pcm_wr, pcmout
  );

  modport slave (
    input  cen55, clr, enable, period, din_we, din,
    output full, empty, level, overflow, underrun, pcm_wr, pcmout
  );
endinterface

// File: rtl/jt12_pcm_feeder.sv
// PCM sample feeder: FIFO of CPU-written samples replayed to the interpolator every `period` cen55 ticks,
// each sample followed by one setup clock and a WRLEN-clock pcm_wr strobe.
module jt12_pcm_feeder #(
  parameter int DW    = 9,
  parameter int AW    = 4,
  parameter int PERW  = 8,
  parameter int WRLEN = 4
) (
  input  logic               clk,
  input  logic               rst,
  jt12_pcm_feeder_if.slave   bus
);
  localparam int DEPTH = 1 << AW;
  localparam int WCW   = (WRLEN > 1) ? $clog2(WRLEN) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, STROBE} state_t;

  logic [DW-1:0]   r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_level;
  logic            r_full;
  logic            r_empty;
  logic            r_overflow;
  logic            r_underrun;
  logic [DW-1:0]   r_pcmout;
  logic [PERW-1:0] r_cnt;
  logic [WCW-1:0]  r_wcnt;
  state_t          r_state;
  state_t          w_state_nxt;

  logic            w_run;
  logic            w_at_end;
  logic            w_tick;
  logic            w_push;
  logic            w_pop;
  logic            w_underrun;
  logic            w_pcm_wr;
  logic            w_strobe_last;
  logic [AW:0]     w_level_nxt;

  // >= rather than == so a period shortened mid-count fires on the very next cen55
  assign w_run         = bus.enable && (bus.period != '0);
  assign w_at_end      = (r_cnt >= (bus.period - PERW'(1)));
  assign w_tick        = bus.cen55 && w_run && !bus.clr && w_at_end;
  assign w_push        = bus.din_we && !r_full && !bus.clr;
  assign w_strobe_last = (r_wcnt == WCW'(WRLEN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (bus.clr || !w_run) begin
      r_cnt <= '0;
    end else if (bus.cen55) begin
      r_cnt <= w_at_end ? '0 : r_cnt + PERW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.clr) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_tick) w_state_nxt = LOAD;
        LOAD:    w_state_nxt = STROBE;
        STROBE:  if (w_strobe_last) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Ticks outside IDLE are dropped; an empty FIFO still strobes, repeating the last sample
  always_comb begin
    w_pop      = 1'b0;
    w_underrun = 1'b0;
    w_pcm_wr   = 1'b0;
    case (r_state)
      IDLE: begin
        w_pop      = w_tick && !r_empty;
        w_underrun = w_tick && r_empty;
      end
      STROBE:  w_pcm_wr = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 r_wcnt <= '0;
    else if (r_state == STROBE && !bus.clr)  r_wcnt <= r_wcnt + WCW'(1);
    else                                     r_wcnt <= '0;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= bus.din;
  end

  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + (AW+1)'(1);
      2'b01:   w_level_nxt = r_level - (AW+1)'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else if (bus.clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == (AW+1)'(DEPTH));
      r_empty <= (w_level_nxt == '0);
    end
  end

  // clr deliberately leaves the held sample untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pcmout   <= '0;
      r_overflow <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_overflow <= bus.din_we && r_full && !bus.clr;
      r_underrun <= w_underrun;
      if (w_pop) r_pcmout <= r_mem[r_rptr];
    end
  end

  assign bus.full     = r_full;
  assign bus.empty    = r_empty;
  assign bus.level    = r_level;
  assign bus.overflow = r_overflow;
  assign bus.underrun = r_underrun;
  assign bus.pcm_wr   = w_pcm_wr;
  assign bus.pcmout   = r_pcmout;
endmodule

// File: tb/tb_jt12_pcm_feeder.sv
// Directed bench for jt12_pcm_feeder: pacing, underrun, fill/overflow, simultaneous push/pop, rst/clr, period changes.
module tb_jt12_pcm_feeder;
  logic clk = 1'b0;
  logic rst;
  int   vecCount = 0;
  int   errCount = 0;

  jt12_pcm_feeder_if #(.DW(9), .AW(4), .PERW(8)) bus ();

  jt12_pcm_feeder #(.DW(9), .AW(4), .PERW(8), .WRLEN(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Every wait ends 1 time unit after a rising edge, so drives and samples sit away from the edge
  task automatic stepClk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pushSample(input logic [8:0] v);
    bus.din    = v;
    bus.din_we = 1'b1;
    stepClk(1);
    bus.din_we = 1'b0;
  endtask

  task automatic pulseCen();
    bus.cen55 = 1'b1;
    stepClk(1);
    bus.cen55 = 1'b0;
  endtask

  task automatic clearFifo();
    bus.clr = 1'b1;
    stepClk(1);
    bus.clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.cen55 = 1'b0; bus.clr = 1'b0; bus.enable = 1'b0; bus.period = 8'd0;
    bus.din_we = 1'b0; bus.din = 9'd0;
    stepClk(3);
    vecCount++; if (bus.level !== 5'd0) begin errCount++; $display("[TB] FAIL reset_level: got %0d, expected 0", bus.level); end
    vecCount++; if (bus.empty !== 1'b1) begin errCount++; $display("[TB] FAIL reset_empty: got %b, expected 1", bus.empty); end
    vecCount++; if (bus.full !== 1'b0) begin errCount++; $display("[TB] FAIL reset_full: got %b, expected 0", bus.full); end
    vecCount++; if ({bus.overflow, bus.underrun} !== 2'b00) begin errCount++; $display("[TB] FAIL reset_pulses: got %b, expected 00", {bus.overflow, bus.underrun}); end
    vecCount++; if (bus.pcm_wr !== 1'b0) begin errCount++; $display("[TB] FAIL reset_pcm_wr: got %b, expected 0", bus.pcm_wr); end
    vecCount++; if (bus.pcmout !== 9'h000) begin errCount++; $display("[TB] FAIL reset_pcmout: got %h, expected 000", bus.pcmout); end
    rst = 1'b0;
    stepClk(1);
  endtask

  task automatic test_pacing();
    logic [8:0] expv [3];
    logic       sawWr;
    expv[0] = 9'h010; expv[1] = 9'h1F0; expv[2] = 9'h055;
    for (int i = 0; i < 3; i++) pushSample(expv[i]);
    bus.period = 8'd2;
    bus.enable = 1'b1;
    for (int n = 0; n < 6; n++) begin
      pulseCen();
      if (n % 2 == 1) begin
        vecCount++; if ({bus.pcm_wr, bus.pcmout} !== {1'b0, expv[n/2]}) begin errCount++; $display("[TB] FAIL pacing_setup%0d: got wr=%b data=%h, expected wr=0 data=%h", n, bus.pcm_wr, bus.pcmout, expv[n/2]); end
        for (int c = 0; c < 4; c++) begin
          stepClk(1);
          vecCount++; if ({bus.pcm_wr, bus.pcmout} !== {1'b1, expv[n/2]}) begin errCount++; $display("[TB] FAIL pacing_strobe%0d_%0d: got wr=%b data=%h, expected wr=1 data=%h", n, c, bus.pcm_wr, bus.pcmout, expv[n/2]); end
        end
        stepClk(1);
        vecCount++; if ({bus.pcm_wr, bus.pcmout} !== {1'b0, expv[n/2]}) begin errCount++; $display("[TB] FAIL pacing_fall%0d: got wr=%b data=%h, expected wr=0 data=%h", n, bus.pcm_wr, bus.pcmout, expv[n/2]); end
        stepClk(1);
      end else begin
        sawWr = bus.pcm_wr;
        for (int c = 0; c < 6; c++) begin
          stepClk(1);
          sawWr |= bus.pcm_wr;
        end
        vecCount++; if (sawWr !== 1'b0) begin errCount++; $display("[TB] FAIL pacing_skip%0d: got pcm_wr=%b, expected 0", n, sawWr); end
      end
      stepClk(1);
    end
    vecCount++; if (bus.empty !== 1'b1) begin errCount++; $display("[TB] FAIL pacing_empty: got %b, expected 1", bus.empty); end
    bus.enable = 1'b0;
  endtask

  task automatic test_underrun();
    clearFifo();
    pushSample(9'h0A0);
    bus.period = 8'd1;
    bus.enable = 1'b1;
    pulseCen();
    vecCount++; if ({bus.underrun, bus.pcmout} !== {1'b0, 9'h0A0}) begin errCount++; $display("[TB] FAIL under_first: got un=%b data=%h, expected un=0 data=0a0", bus.underrun, bus.pcmout); end
    stepClk(7);
    vecCount++; if (bus.empty !== 1'b1) begin errCount++; $display("[TB] FAIL under_empty: got %b, expected 1", bus.empty); end
    pulseCen();
    vecCount++; if ({bus.underrun, bus.pcm_wr, bus.pcmout} !== {2'b10, 9'h0A0}) begin errCount++; $display("[TB] FAIL under_pulse: got un=%b wr=%b data=%h, expected un=1 wr=0 data=0a0", bus.underrun, bus.pcm_wr, bus.pcmout); end
    stepClk(1);
    vecCount++; if ({bus.underrun, bus.pcm_wr, bus.pcmout} !== {2'b01, 9'h0A0}) begin errCount++; $display("[TB] FAIL under_strobe: got un=%b wr=%b data=%h, expected un=0 wr=1 data=0a0", bus.underrun, bus.pcm_wr, bus.pcmout); end
    stepClk(6);
    bus.enable = 1'b0;
  endtask

  task automatic test_fill();
    clearFifo();
    for (int i = 0; i < 16; i++) pushSample(9'(9'h100 + i));
    vecCount++; if ({bus.full, bus.level, bus.overflow} !== {1'b1, 5'd16, 1'b0}) begin errCount++; $display("[TB] FAIL fill_full: got full=%b level=%0d ovf=%b, expected 1/16/0", bus.full, bus.level, bus.overflow); end
    pushSample(9'h1FF);
    vecCount++; if ({bus.full, bus.level, bus.overflow} !== {1'b1, 5'd16, 1'b1}) begin errCount++; $display("[TB] FAIL fill_overflow: got full=%b level=%0d ovf=%b, expected 1/16/1", bus.full, bus.level, bus.overflow); end
    stepClk(1);
    vecCount++; if (bus.overflow !== 1'b0) begin errCount++; $display("[TB] FAIL fill_ovf_pulse: got %b, expected 0", bus.overflow); end
    bus.period = 8'd1;
    bus.enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      pulseCen();
      vecCount++; if (bus.pcmout !== 9'(9'h100 + i)) begin errCount++; $display("[TB] FAIL fill_drain%0d: got %h, expected %h", i, bus.pcmout, 9'(9'h100 + i)); end
      stepClk(7);
    end
    vecCount++; if ({bus.empty, bus.level} !== {1'b1, 5'd0}) begin errCount++; $display("[TB] FAIL fill_drained: got empty=%b level=%0d, expected 1/0", bus.empty, bus.level); end
    bus.enable = 1'b0;
  endtask

  task automatic test_back_to_back();
    clearFifo();
    for (int i = 0; i < 5; i++) pushSample(9'(9'h011 + i));
    bus.period = 8'd1;
    bus.enable = 1'b1;
    bus.din = 9'h016; bus.din_we = 1'b1; bus.cen55 = 1'b1;
    stepClk(1);
    bus.din_we = 1'b0; bus.cen55 = 1'b0;
    vecCount++; if ({bus.level, bus.pcmout} !== {5'd5, 9'h011}) begin errCount++; $display("[TB] FAIL b2b_level: got level=%0d data=%h, expected 5/011", bus.level, bus.pcmout); end
    stepClk(7);
    for (int i = 0; i < 11; i++) pushSample(9'(9'h017 + i));
    vecCount++; if ({bus.full, bus.level} !== {1'b1, 5'd16}) begin errCount++; $display("[TB] FAIL b2b_full: got full=%b level=%0d, expected 1/16", bus.full, bus.level); end
    bus.din = 9'h1EE; bus.din_we = 1'b1; bus.cen55 = 1'b1;
    stepClk(1);
    bus.din_we = 1'b0; bus.cen55 = 1'b0;
    vecCount++; if ({bus.overflow, bus.level, bus.pcmout} !== {1'b1, 5'd15, 9'h012}) begin errCount++; $display("[TB] FAIL b2b_full_pop: got ovf=%b level=%0d data=%h, expected 1/15/012", bus.overflow, bus.level, bus.pcmout); end
    stepClk(7);
    bus.enable = 1'b0;
  endtask

  task automatic test_reset_clr();
    logic sawWr;
    clearFifo();
    pushSample(9'h0C3);
    bus.period = 8'd1;
    bus.enable = 1'b1;
    pulseCen();
    stepClk(2);
    vecCount++; if ({bus.pcm_wr, bus.pcmout} !== {1'b1, 9'h0C3}) begin errCount++; $display("[TB] FAIL rst_pre: got wr=%b data=%h, expected 1/0c3", bus.pcm_wr, bus.pcmout); end
    #2 rst = 1'b1;
    #1;
    vecCount++; if ({bus.pcm_wr, bus.pcmout} !== {1'b0, 9'h000}) begin errCount++; $display("[TB] FAIL rst_async: got wr=%b data=%h, expected 0/000", bus.pcm_wr, bus.pcmout); end
    #1 rst = 1'b0;
    stepClk(1);
    pushSample(9'h0C5);
    pushSample(9'h0C6);
    pulseCen();
    stepClk(2);
    vecCount++; if ({bus.pcm_wr, bus.pcmout} !== {1'b1, 9'h0C5}) begin errCount++; $display("[TB] FAIL clr_pre: got wr=%b data=%h, expected 1/0c5", bus.pcm_wr, bus.pcmout); end
    clearFifo();
    vecCount++; if ({bus.pcm_wr, bus.level, bus.empty, bus.pcmout} !== {1'b0, 5'd0, 1'b1, 9'h0C5}) begin errCount++; $display("[TB] FAIL clr_abort: got wr=%b level=%0d empty=%b data=%h, expected 0/0/1/0c5", bus.pcm_wr, bus.level, bus.empty, bus.pcmout); end
    sawWr = 1'b0;
    for (int c = 0; c < 4; c++) begin
      stepClk(1);
      sawWr |= bus.pcm_wr;
    end
    vecCount++; if (sawWr !== 1'b0) begin errCount++; $display("[TB] FAIL clr_no_resume: got pcm_wr=%b, expected 0", sawWr); end
    bus.enable = 1'b0;
  endtask

  task automatic test_period();
    logic sawWr;
    clearFifo();
    for (int i = 0; i < 4; i++) pushSample(9'(9'h031 + i));
    bus.period = 8'd10;
    bus.enable = 1'b1;
    for (int k = 0; k < 7; k++) begin
      pulseCen();
      stepClk(7);
    end
    vecCount++; if (bus.level !== 5'd4) begin errCount++; $display("[TB] FAIL period_count7: got level=%0d, expected 4", bus.level); end
    bus.period = 8'd3;
    pulseCen();
    vecCount++; if ({bus.level, bus.pcmout} !== {5'd3, 9'h031}) begin errCount++; $display("[TB] FAIL period_shrink: got level=%0d data=%h, expected 3/031", bus.level, bus.pcmout); end
    stepClk(7);
    bus.period = 8'd0;
    sawWr = 1'b0;
    for (int k = 0; k < 4; k++) begin
      pulseCen();
      sawWr |= bus.pcm_wr;
      for (int c = 0; c < 7; c++) begin
        stepClk(1);
        sawWr |= bus.pcm_wr;
      end
    end
    vecCount++; if ({sawWr, bus.level, bus.pcmout} !== {1'b0, 5'd3, 9'h031}) begin errCount++; $display("[TB] FAIL period_zero: got wr_seen=%b level=%0d data=%h, expected 0/3/031", sawWr, bus.level, bus.pcmout); end
    bus.enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pacing();
    test_underrun();
    test_fill();
    test_back_to_back();
    test_reset_clr();
    test_period();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end
endmodule
